// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

    localparam int unsigned PC_W   = 12;
    localparam int unsigned ADDR_W = 16;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

    // Sequential successor of a word PC, wrapping modulo 4096.
    function automatic pc_t pc_incr(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage : cpu_pkg

// File: rtl/pc_addr_map.sv
// Maps a word PC onto the 16-bit byte address seen by instruction memory.
module pc_addr_map
    import cpu_pkg::*;
(
    input  pc_t   pc_i,
    output addr_t addr_o
);

    assign addr_o = {2'b00, pc_i, 2'b00};

endmodule : pc_addr_map

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues one fetch at a time, follows branches,
// stalls and halts, and reports completed fetches to the pipeline.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter pc_t RESET_PC = 12'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              halt_req,
    input  logic              mem_ack,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              instr_valid,
    output logic              pc_wrap,
    output logic              halted
);

    seq_state_t state_q, state_d;
    pc_t        pc_q, pc_d;
    pc_t        pend_pc_q, pend_pc_d;
    logic       pend_vld_q, pend_vld_d;
    logic       fetch_req_q, fetch_req_d;
    logic       instr_valid_q, instr_valid_d;
    logic       pc_wrap_q, pc_wrap_d;
    logic       halted_q, halted_d;

    // Next-state and next-output decode.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        pend_vld_d    = pend_vld_q;
        instr_valid_d = 1'b0;
        pc_wrap_d     = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d    = S_FETCH;
                    pc_d       = RESET_PC;
                    pend_vld_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    // A fetch issued before a redirect is wrong-path: squash it.
                    instr_valid_d = ~pend_vld_q;
                    pend_vld_d    = 1'b0;
                    if (branch_taken) begin
                        pc_d = branch_target;
                    end else if (pend_vld_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d      = pc_incr(pc_q);
                        pc_wrap_d = (pc_q == '1);
                    end
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (stall) begin
                        state_d = S_STALL;
                    end
                end else if (halt_req) begin
                    state_d    = S_HALT;
                    pend_vld_d = 1'b0;
                end else begin
                    // Address must stay stable until ack, so park the redirect.
                    if (branch_taken) begin
                        pend_vld_d = 1'b1;
                        pend_pc_d  = branch_target;
                    end
                    if (stall) begin
                        state_d = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (halt_req) begin
                    state_d    = S_HALT;
                    pend_vld_d = 1'b0;
                end else if (branch_taken) begin
                    pc_d       = branch_target;
                    pend_vld_d = 1'b0;
                end else if (!stall) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fetch_req_d = (state_d == S_FETCH);
        halted_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            pend_vld_q    <= 1'b0;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            pc_wrap_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            pend_vld_q    <= pend_vld_d;
            fetch_req_q   <= fetch_req_d;
            instr_valid_q <= instr_valid_d;
            pc_wrap_q     <= pc_wrap_d;
            halted_q      <= halted_d;
        end
    end

    pc_addr_map u_addr_map (
        .pc_i   (pc_q),
        .addr_o (fetch_addr)
    );

    assign pc          = pc_q;
    assign fetch_req   = fetch_req_q;
    assign instr_valid = instr_valid_q;
    assign pc_wrap     = pc_wrap_q;
    assign halted      = halted_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        halt_req;
    logic        mem_ack;
    logic [11:0] pc;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        instr_valid;
    logic        pc_wrap;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(.RESET_PC(12'h000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .mem_ack       (mem_ack),
        .pc            (pc),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .instr_valid   (instr_valid),
        .pc_wrap       (pc_wrap),
        .halted        (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compact status check: pc, fetch_req, instr_valid, pc_wrap, halted.
    task automatic expect_st(input string tag, input logic [11:0] e_pc, input logic e_req,
                             input logic e_iv, input logic e_wrap, input logic e_halt);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".req"}, 32'(fetch_req), 32'(e_req));
        check({tag, ".iv"}, 32'(instr_valid), 32'(e_iv));
        check({tag, ".wrap"}, 32'(pc_wrap), 32'(e_wrap));
        check({tag, ".halt"}, 32'(halted), 32'(e_halt));
        check({tag, ".addr"}, 32'(fetch_addr), 32'({2'b00, e_pc, 2'b00}));
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 12'h000; halt_req = 1'b0; mem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        expect_st("reset", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        rst_n = 1'b1;
        step();
        expect_st("idle", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // halt_req alone in IDLE is ignored; start wins when both are high
        halt_req = 1'b1;
        step();
        expect_st("idle_halt", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        expect_st("start", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0; halt_req = 1'b0; mem_ack = 1'b1;
        step();
        expect_st("seq1", 12'h001, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        expect_st("seq2", 12'h002, 1'b1, 1'b1, 1'b0, 1'b0);

        // branch with ack, then increment across the wrap
        branch_taken = 1'b1; branch_target = 12'hFFE;
        step();
        expect_st("br_ffe", 12'hFFE, 1'b1, 1'b1, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step();
        expect_st("pc_fff", 12'hFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        expect_st("wrap", 12'h000, 1'b1, 1'b1, 1'b1, 1'b0);
        branch_taken = 1'b1; branch_target = 12'h000;
        step();
        expect_st("br_zero", 12'h000, 1'b1, 1'b1, 1'b0, 1'b0);

        // redirect while the fetch is outstanding is parked and squashes the fetch
        branch_taken = 1'b0; mem_ack = 1'b0;
        step();
        expect_st("wait0", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b1; branch_target = 12'h123;
        step();
        expect_st("wait1", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step();
        expect_st("wait2", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        step();
        expect_st("squash", 12'h123, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        expect_st("after_sq", 12'h124, 1'b1, 1'b1, 1'b0, 1'b0);

        // stall together with ack
        branch_taken = 1'b1; branch_target = 12'h010;
        step();
        expect_st("br_010", 12'h010, 1'b1, 1'b1, 1'b0, 1'b0);
        branch_taken = 1'b0; stall = 1'b1;
        step();
        expect_st("stall_ack", 12'h011, 1'b0, 1'b1, 1'b0, 1'b0);
        mem_ack = 1'b0;
        step();
        expect_st("stall_hold", 12'h011, 1'b0, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        expect_st("unstall", 12'h011, 1'b1, 1'b0, 1'b0, 1'b0);

        // stall without ack, then redirect while stalled
        stall = 1'b1;
        step();
        expect_st("stall_noack", 12'h011, 1'b0, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b1; branch_target = 12'h200;
        step();
        expect_st("stall_br", 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b0; stall = 1'b0;
        step();
        expect_st("stall_exit", 12'h200, 1'b1, 1'b0, 1'b0, 1'b0);

        // halt together with ack at ABC, then restart
        mem_ack = 1'b1; branch_taken = 1'b1; branch_target = 12'hABC;
        step();
        expect_st("br_abc", 12'hABC, 1'b1, 1'b1, 1'b0, 1'b0);
        branch_taken = 1'b0; halt_req = 1'b1;
        step();
        expect_st("halt_ack", 12'hABD, 1'b0, 1'b1, 1'b0, 1'b1);
        halt_req = 1'b0; mem_ack = 1'b0;
        step();
        expect_st("halted", 12'hABD, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        step();
        expect_st("restart", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;

        // halt without ack discards the parked redirect
        branch_taken = 1'b1; branch_target = 12'h555;
        step();
        branch_taken = 1'b0; halt_req = 1'b1;
        step();
        expect_st("halt_noack", 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        halt_req = 1'b0; start = 1'b1;
        step();
        start = 1'b0; mem_ack = 1'b1;
        step();
        expect_st("no_stale_br", 12'h001, 1'b1, 1'b1, 1'b0, 1'b0);

        // asynchronous reset mid-fetch with a parked redirect
        mem_ack = 1'b0; branch_taken = 1'b1; branch_target = 12'h777;
        step();
        branch_taken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        expect_st("async_rst", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        #2 rst_n = 1'b1;
        step();
        expect_st("rst_release", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        expect_st("rst_start", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        step();
        expect_st("rst_fetch", 12'h001, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 12'h000: PC loaded on reset and on start.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  leave IDLE/HALT and begin fetching at RESET_PC.
REQ-005 stall  input  1  pipeline back-pressure; suspends new fetches.
REQ-006 branch_taken  input  1  redirect request; branch_target is valid in the same cycle.
REQ-007 branch_target  input  12  word PC of the redirect.
REQ-008 halt_req  input  1  stop sequencing.
REQ-009 mem_ack  input  1  instruction memory accepts and returns the current fetch.
REQ-010 pc  output  12  current word PC, registered.
REQ-011 fetch_req  output  1  fetch request, high only in FETCH.
REQ-012 fetch_addr  output  16  byte address, equal to {2'b00, pc, 2'b00}.
REQ-013 instr_valid  output  1  one-cycle pulse, fetched instruction is usable.
REQ-014 pc_wrap  output  1  one-cycle pulse when the PC increments from 12'hFFF to 12'h000.
REQ-015 halted  output  1  high in HALT.

Function
REQ-016 States: IDLE, FETCH, STALL, HALT; encoding 2 bits.
- IDLE: start -> FETCH, pc <= RESET_PC.
- HALT: start -> FETCH, pc <= RESET_PC.
REQ-017 Handshake: fetch_req and fetch_addr stay stable from assertion until the cycle mem_ack=1.
- A fetch completes in that ack cycle; the earliest ack is the same cycle fetch_req rises.
REQ-018 On completion, instr_valid=1 next cycle and pc <= next_pc.
- next_pc = branch_target if branch_taken, else the pending target if one is held, else pc+1 (modulo 4096).
REQ-019 FETCH with no ack: stay in FETCH.
- Exception: stall=1 -> STALL, with fetch_req low from the next cycle.
REQ-020 Ack together with stall=1 in FETCH: complete the fetch, then STALL.
REQ-021 STALL: pc is held; stall=0 -> FETCH next cycle.
- branch_taken in STALL: pc <= branch_target and stay in STALL.
REQ-022 Branch during FETCH without ack:
- Capture branch_target in the pending register; pc and fetch_addr do not change.
- At the following ack: instr_valid stays low (squash), pc <= pending target, pending clears.
REQ-023 halt_req in FETCH or STALL -> HALT next cycle.
- halt_req and ack in the same FETCH cycle: the ack completes normally, then HALT.
- Pending branch is discarded; pc is held.
REQ-024 halt_req in IDLE or HALT is ignored; start has priority over halt_req in IDLE/HALT.
REQ-025 pc_wrap pulses only on an increment wrap, never on a branch to 12'h000.
REQ-026 Priority within FETCH: ack completion > halt_req > stall.

Reset
REQ-027 rst_n=0 forces, without waiting for a clock edge:
- state IDLE, pc=RESET_PC, fetch_addr={2'b00,RESET_PC,2'b00};
- fetch_req=0, instr_valid=0, pc_wrap=0, halted=0;
- pending branch cleared.
REQ-028 Reset mid-fetch abandons the outstanding request; no instr_valid follows reset release.

Structure
REQ-029 Shared package cpu_pkg holds:
- typedef pc_t (12-bit), typedef addr_t (16-bit), enum seq_state_t;
- constant PC_W=12, ADDR_W=16.
REQ-030 One sub-module, pc_addr_map: combinational mapping of pc_t to addr_t ({2'b00, pc, 2'b00}) that drives fetch_addr.

Verification
REQ-031 Scenario: reset, start, mem_ack tied 1 -> pc sequence 000,001,002; fetch_addr 0000,0004,0008; instr_valid high each cycle.
REQ-032 Scenario: pc=12'hFFE, ack for 2 fetches -> pc FFF then 000; pc_wrap pulses once; fetch_addr 3FFC then 0000.
REQ-033 Scenario: in FETCH with ack held low 3 cycles, branch_taken with target 12'h123 in cycle 1, then ack:
- fetch_addr is unchanged during the wait;
- instr_valid stays 0 (squashed);
- pc=12'h123 next.
REQ-034 Scenario: stall=1 together with ack at pc=12'h010 -> pc=12'h011, STALL, fetch_req=0; stall=0 -> FETCH at 12'h011.
REQ-035 Scenario: halt_req with ack in the same cycle at pc=12'hABC -> instr_valid=1, pc=12'hABD, halted=1; then start -> pc=RESET_PC, FETCH.
REQ-036 Scenario: rst_n low mid-FETCH between clock edges -> all outputs reach reset values immediately; no instr_valid after release.
